primo_seq: RTL

Sequential, parametrised successor to the combinational 16-bit prime detector. It accepts a W-bit operand on a start/done handshake and decides primality by multi-cycle odd trial division. Besides the prime flag, it reports the smallest prime factor. It sits on the course datapath as a shared arithmetic unit, with one divider reused across trials in place of an unrolled combinational loop.

---
 rtl/primo_pkg.sv | 28 ++
 rtl/primo_rem.sv | 76 +++++++
 rtl/primo_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/primo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : primo_pkg                                                    |
// | Description : Shared types and constants for the sequential prime unit.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package primo_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // First odd trial divisor and its square
  localparam int FIRST_DIV = 3;
  localparam int FIRST_SQ  = 9;

  // Worst-case number of trials for a w-bit operand: odd i in 3 .. 2^(w/2)-1
  function automatic int trial_count(input int w);
    return (1 << (w / 2 - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/primo_rem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : primo_rem                                                    |
// | Description : Sequential restoring remainder unit, one dividend bit per   |
// |               cycle, MSB first, exactly W cycles per operation.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module primo_rem
  import primo_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic         rem_done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  part_r;
  logic [W-1:0]  shift_r;
  logic [W-1:0]  dvsr_r;
  logic [CW-1:0] cnt_r;
  logic          active_r;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so {part, bit} fits W+1 bits.
  function automatic logic [W-1:0] rem_step(input logic [W-1:0] part,
                                            input logic         bit_in,
                                            input logic [W-1:0] dv);
    logic [W:0] trial;
    trial = {part, bit_in};
    if (trial >= {1'b0, dv}) rem_step = W'(trial - {1'b0, dv});
    else                     rem_step = trial[W-1:0];
  endfunction

  // The go edge performs the first step straight from the dividend input,
  // so the W-th step lands one edge before rem_done is observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_r   <= '0;
      shift_r  <= '0;
      dvsr_r   <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
      rem_done <= 1'b0;
    end else if (go) begin
      part_r   <= rem_step('0, dividend[W-1], divisor);
      shift_r  <= {dividend[W-2:0], 1'b0};
      dvsr_r   <= divisor;
      cnt_r    <= CW'(1);
      active_r <= 1'b1;
      rem_done <= 1'b0;
    end else if (active_r) begin
      part_r   <= rem_step(part_r, shift_r[W-1], dvsr_r);
      shift_r  <= {shift_r[W-2:0], 1'b0};
      cnt_r    <= cnt_r + CW'(1);
      if (cnt_r == CW'(W - 1)) begin
        active_r <= 1'b0;
        rem_done <= 1'b1;
      end else begin
        rem_done <= 1'b0;
      end
    end else begin
      rem_done <= 1'b0;
    end
  end

  assign rem = part_r;

endmodule
`default_nettype wire

// File: rtl/primo_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : primo_seq                                                    |
// | Description : Multi-cycle primality test by odd trial division; reports   |
// |               the prime flag and the smallest prime factor.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module primo_seq
  import primo_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] N,
  output logic         busy,
  output logic         done,
  output logic         F,
  output logic [W-1:0] fator
);

  localparam int SW = 2 * W;

  state_t        state;
  logic [W-1:0]  n_r;
  logic [W-1:0]  i_r;
  logic [SW-1:0] sq_r;

  logic [SW-1:0] n_ext;
  logic [SW-1:0] sq_next;
  logic [W-1:0]  i_next;
  logic [W-1:0]  div_in;
  logic          rem_go;
  logic [W-1:0]  rem;
  logic          rem_done;

  // Next trial divisor/square and the launch request for the remainder unit
  always_comb begin
    n_ext   = {{W{1'b0}}, n_r};
    i_next  = i_r + W'(2);
    sq_next = sq_r + {{(W-2){1'b0}}, i_r, 2'b00} + SW'(4);
    div_in  = (state == CHECK) ? W'(FIRST_DIV) : i_next;
    rem_go  = 1'b0;
    if (state == CHECK)
      rem_go = (n_r > W'(2)) && n_r[0] && (SW'(FIRST_SQ) <= n_ext);
    else if (state == NEXT)
      rem_go = (rem != '0) && (sq_next <= n_ext);
  end

  primo_rem #(.W(W)) u_rem (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (rem_go),
    .dividend (n_r),
    .divisor  (div_in),
    .rem      (rem),
    .rem_done (rem_done)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n_r   <= '0;
      i_r   <= '0;
      sq_r  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      F     <= 1'b0;
      fator <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_r   <= N;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (n_r <= W'(1)) begin
            F     <= 1'b0;
            fator <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else if (n_r == W'(2)) begin
            F     <= 1'b1;
            fator <= W'(2);
            done  <= 1'b1;
            state <= DONE;
          end else if (!n_r[0]) begin
            F     <= 1'b0;
            fator <= W'(2);
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i_r  <= W'(FIRST_DIV);
            sq_r <= SW'(FIRST_SQ);
            if (SW'(FIRST_SQ) > n_ext) begin
              // 3, 5 and 7 need no trial at all
              F     <= 1'b1;
              fator <= n_r;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (rem_done) state <= NEXT;
        end
        NEXT: begin
          if (rem == '0) begin
            F     <= 1'b0;
            fator <= i_r;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i_r  <= i_next;
            sq_r <= sq_next;
            if (sq_next > n_ext) begin
              F     <= 1'b1;
              fator <= n_r;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
